// File: rtl/code_inverter.sv
// ---------------------------------------------------------------------------
// code_inverter
//   Finds every 8-bit preimage c with F(c) == req_code, where F is a fixed
//   piecewise forward map. Candidates 0x00..0xFF are scanned in ascending
//   order, one per cycle. Each match is emitted as one response beat, and
//   every request ends with a single terminating beat (rsp_end=1,
//   rsp_data=0x00).
//
// Ports
//   clk        in   1  clock, rising edge
//   rst        in   1  synchronous active-high reset
//   req_valid  in   1  request offered
//   req_ready  out  1  block can accept a request (IDLE only)
//   req_code   in   8  target code to invert
//   rsp_valid  out  1  response beat present
//   rsp_ready  in   1  consumer accepts beat
//   rsp_data   out  8  preimage value, 0x00 on the end beat
//   rsp_end    out  1  terminating beat of a request
//   busy       out  1  request in progress
//   match_cnt  out  9  preimages emitted for the current request
//                      (only when CODE_INV_CNT_EN is defined)
//
// Configuration macro: CODE_INV_CNT_EN adds the match_cnt port and counter.
// ---------------------------------------------------------------------------
module code_inverter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_code,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_end,
  output logic       busy
`ifdef CODE_INV_CNT_EN
  ,
  output logic [8:0] match_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    EMIT = 2'd2,
    END  = 2'd3
  } state_t;

  // Forward map F; all arithmetic wraps modulo 256.
  function automatic logic [7:0] fwd_map(input logic [7:0] x);
    logic [7:0] y;
    if (x == 8'hFF) begin
      y = 8'hFE;
    end else if (x >= 8'hF9) begin
      y = x + 8'h0F;
    end else if (x >= 8'hE1) begin
      y = x - 8'h10;
    end else if (x >= 8'hA1) begin
      y = x - 8'h11;
    end else if (x >= 8'h81) begin
      y = x - 8'h22;
    end else if (x >= 8'h41) begin
      y = x - 8'h33;
    end else if (x >= 8'h01) begin
      y = x - 8'h44;
    end else begin
      y = 8'h00;
    end
    return y;
  endfunction

  state_t     r_state;
  logic [7:0] r_cand;
  logic [7:0] r_code;
  logic [7:0] r_rsp_data;
  logic       r_rsp_valid;
  logic       r_rsp_end;
  logic       r_req_ready;
  logic       r_busy;

  state_t     w_state_nxt;
  logic [7:0] w_cand_nxt;
  logic [7:0] w_code_nxt;
  logic [7:0] w_data_nxt;
  logic       w_match;

  assign w_match = (fwd_map(r_cand) == r_code);

  // Next-state, candidate and response-data selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_code;
    w_data_nxt  = r_rsp_data;
    case (r_state)
      IDLE: begin
        if (req_valid && r_req_ready) begin
          w_state_nxt = SCAN;
          w_cand_nxt  = 8'h00;
          w_code_nxt  = req_code;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SCAN: begin
        if (w_match) begin
          // Candidate is held so EMIT knows whether it was the last one.
          w_state_nxt = EMIT;
          w_data_nxt  = r_cand;
        end else if (r_cand == 8'hFF) begin
          w_state_nxt = END;
          w_data_nxt  = 8'h00;
        end else begin
          w_cand_nxt  = r_cand + 8'h01;
        end
      end
      EMIT: begin
        if (rsp_ready) begin
          if (r_cand == 8'hFF) begin
            w_state_nxt = END;
            w_data_nxt  = 8'h00;
          end else begin
            w_state_nxt = SCAN;
            w_cand_nxt  = r_cand + 8'h01;
          end
        end else begin
          w_state_nxt = EMIT;
        end
      end
      END: begin
        if (rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = END;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cand_nxt  = 8'h00;
        w_data_nxt  = 8'h00;
      end
    endcase
  end

  // State, datapath and registered output flags (decoded from next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cand      <= 8'h00;
      r_code      <= 8'h00;
      r_rsp_data  <= 8'h00;
      r_rsp_valid <= 1'b0;
      r_rsp_end   <= 1'b0;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cand      <= w_cand_nxt;
      r_code      <= w_code_nxt;
      r_rsp_data  <= w_data_nxt;
      r_rsp_valid <= (w_state_nxt == EMIT) || (w_state_nxt == END);
      r_rsp_end   <= (w_state_nxt == END);
      r_req_ready <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_end   = r_rsp_end;
  assign busy      = r_busy;

`ifdef CODE_INV_CNT_EN
  logic [8:0] r_match_cnt;

  // Match counter: cleared on accept, bumped on each data-beat handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match_cnt <= 9'd0;
    end else if ((r_state == IDLE) && req_valid && r_req_ready) begin
      r_match_cnt <= 9'd0;
    end else if ((r_state == EMIT) && rsp_ready) begin
      r_match_cnt <= r_match_cnt + 9'd1;
    end else begin
      r_match_cnt <= r_match_cnt;
    end
  end

  assign match_cnt = r_match_cnt;
`endif

endmodule

// File: tb/tb_code_inverter.sv
module tb_code_inverter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [7:0] req_code = 8'h00;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_end;
  logic       busy;
`ifdef CODE_INV_CNT_EN
  logic [8:0] match_cnt;
`endif

  code_inverter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_code  (req_code),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_end   (rsp_end),
    .busy      (busy)
`ifdef CODE_INV_CNT_EN
    ,
    .match_cnt (match_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err = 0;
  int          cyc = 0;
  logic [15:0] exp_q[$];
  bit          end_seen = 1'b0;
  int          end_cyc = 0;
  int          acc_cyc = 0;
  int          nbeats = 0;
  int          nexp = 0;
  int          hit[256];
  bit          stall_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference forward map written from the range table.
  function automatic logic [7:0] model_f(input logic [7:0] x);
    case (x) inside
      8'hFF:          return 8'hFE;
      [8'hF9:8'hFE]:  return x + 8'h0F;
      [8'hE1:8'hF8]:  return x - 8'h10;
      [8'hA1:8'hE0]:  return x - 8'h11;
      [8'h81:8'hA0]:  return x - 8'h22;
      [8'h41:8'h80]:  return x - 8'h33;
      [8'h01:8'h40]:  return x - 8'h44;
      default:        return 8'h00;
    endcase
  endfunction

  task automatic push_exp(input logic [7:0] code);
    logic [7:0] c;
    nexp = 0;
    for (int i = 0; i < 256; i++) begin
      c = i[7:0];
      if (model_f(c) == code) begin
        exp_q.push_back({8'h00, c});
        nexp++;
      end
    end
    exp_q.push_back(16'h0100);
  endtask

  // Consumer readiness: always ready, or random stalls.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      rsp_ready = stall_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  // Monitor: scoreboard pops, stall stability, req_ready/busy relation.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      check_eq("rdy_vs_busy", {15'd0, req_ready}, {15'd0, ~busy});
      if (prev_stall) begin
        check_eq("stall_valid", {15'd0, rsp_valid}, 16'd1);
        check_eq("stall_data", {8'd0, rsp_data}, {8'd0, prev_data});
      end
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_extra", {7'd0, rsp_end, rsp_data}, 16'hFFFF);
        end else begin
          check_eq("beat", {7'd0, rsp_end, rsp_data}, exp_q.pop_front());
        end
        if (rsp_end) begin
          end_seen = 1'b1;
          end_cyc  = cyc + 1;
        end else begin
          nbeats++;
          hit[rsp_data]++;
        end
      end
      prev_stall = rsp_valid && !rsp_ready;
      prev_data  = rsp_data;
    end
  end

  task automatic accept(input logic [7:0] code, output int waited);
    waited = 0;
    do begin
      @(posedge clk);
      #1;
      waited++;
    end while (!req_ready && waited < 2000);
    push_exp(code);
    end_seen  = 1'b0;
    req_valid = 1'b1;
    req_code  = code;
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    req_valid = 1'b0;
    req_code  = 8'($urandom);
  endtask

  task automatic run_req(input logic [7:0] code, output int waited);
    int t;
    accept(code, waited);
    t = 0;
    while (!end_seen && t < 3000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (!end_seen) check_eq("end_timeout", 16'd0, 16'd1);
    check_eq("q_drained", exp_q.size() == 0 ? 16'd0 : 16'd1, 16'd0);
`ifdef CODE_INV_CNT_EN
    check_eq("match_cnt", {7'd0, match_cnt}, nexp[15:0]);
`endif
  endtask

  initial begin
    int w;
    int t;
    int b0;
    // Reset with a request offered: reset wins.
    req_valid = 1'b1;
    req_code  = 8'hC0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {15'd0, req_ready}, 16'd1);
    check_eq("rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check_eq("rst_rsp_end", {15'd0, rsp_end}, 16'd0);
    check_eq("rst_rsp_data", {8'd0, rsp_data}, 16'd0);
    check_eq("rst_busy", {15'd0, busy}, 16'd0);
`ifdef CODE_INV_CNT_EN
    check_eq("rst_match_cnt", {7'd0, match_cnt}, 16'd0);
`endif
    req_valid = 1'b0;
    rst = 1'b0;

    run_req(8'hC0, w);
    check_eq("c0_count", nexp[15:0], 16'd2);
    run_req(8'h05, w);
    check_eq("latency_no_match", 16'(end_cyc - acc_cyc), 16'd257);
    run_req(8'hFE, w);
    run_req(8'h0A, w);
    run_req(8'h00, w);

    stall_mode = 1'b1;
    run_req(8'hC0, w);
    stall_mode = 1'b0;

    // Reset while scanning after the first beat of 0xC0.
    b0 = nbeats;
    accept(8'hC0, w);
    t = 0;
    while (nbeats == b0 && t < 1000) begin
      @(posedge clk);
      #1;
      t++;
    end
    check_eq("first_beat_seen", 16'(nbeats - b0), 16'd1);
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_req_ready", {15'd0, req_ready}, 16'd1);
    check_eq("mid_rst_rsp_valid", {15'd0, rsp_valid}, 16'd0);
    check_eq("mid_rst_rsp_end", {15'd0, rsp_end}, 16'd0);
    check_eq("mid_rst_rsp_data", {8'd0, rsp_data}, 16'd0);
    check_eq("mid_rst_busy", {15'd0, busy}, 16'd0);
`ifdef CODE_INV_CNT_EN
    check_eq("mid_rst_match_cnt", {7'd0, match_cnt}, 16'd0);
`endif
    exp_q.delete();
    rst = 1'b0;
    repeat (300) @(posedge clk);
    #1;
    check_eq("no_end_after_rst", {15'd0, end_seen}, 16'd0);
    run_req(8'h0A, w);

    // Exhaustive sweep, back-to-back requests.
    for (int i = 0; i < 256; i++) hit[i] = 0;
    for (int i = 0; i < 256; i++) begin
      run_req(i[7:0], w);
      if (i > 0) check_eq("b2b_wait", w[15:0], 16'd1);
    end
    for (int i = 0; i < 256; i++) check_eq("uniq", hit[i][15:0], 16'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/code_inverter.md
CODE_INVERTER -- requirements
Module: code_inverter

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, clock; all logic rising-edge.
REQ-002 rst, input, 1, reset: synchronous, active-high.
REQ-003 req_valid, input, 1, request offered.
REQ-004 req_ready, output, 1, block can accept a request.
REQ-005 req_code, input, 8, target code to invert.
REQ-006 rsp_valid, output, 1, response beat present.
REQ-007 rsp_ready, input, 1, consumer accepts beat.
REQ-008 rsp_data, output, 8, preimage value; 0x00 on end beat.
REQ-009 rsp_end, output, 1, terminating beat of a request.
REQ-010 busy, output, 1, request in progress (not IDLE).
REQ-011 match_cnt, output, 9, preimages emitted for current request; present only with CODE_INV_CNT_EN.

Function
REQ-012 Forward map F (8-bit, mod-256) SHALL be:
- 0xFF -> 0xFE
- 0xF9..0xFE -> x+0x0F
- 0xE1..0xF8 -> x-0x10
- 0xA1..0xE0 -> x-0x11
- 0x81..0xA0 -> x-0x22
- 0x41..0x80 -> x-0x33
- 0x01..0x40 -> x-0x44
- 0x00 -> 0x00
REQ-013 Per request, the block SHALL emit every c with F(c)==req_code, ascending, one per beat, then exactly one end beat.
REQ-014 FSM states SHALL be IDLE, SCAN, EMIT, END.
REQ-015 IDLE: req_ready=1; on req_valid&&req_ready, capture req_code, candidate counter=0x00, go to SCAN.
REQ-016 SCAN: evaluate one candidate per cycle; on match go to EMIT with rsp_data=candidate and rsp_valid=1 next cycle; otherwise increment. After candidate 0xFF, go to END.
REQ-017 EMIT: hold rsp_valid, rsp_data stable until rsp_ready; on handshake, go to END if candidate was 0xFF, else SCAN at candidate+1.
REQ-018 END: rsp_valid=1, rsp_end=1, rsp_data=0x00; on rsp_ready go to IDLE.
REQ-019 req_ready SHALL be 0 in all states except IDLE; req_code changes outside IDLE SHALL be ignored.
REQ-020 Scanning SHALL pause while a beat is pending; no beat is dropped or duplicated under any rsp_ready pattern.
REQ-021 Latency: for an accept at edge T with no matches and rsp_ready=1, the end beat SHALL be valid in cycle T+257.
REQ-022 The candidate counter SHALL NOT wrap past 0xFF; 0xFF is evaluated exactly once per request.
REQ-023 A new request accepted in the cycle after the end-beat handshake SHALL be permitted; there SHALL be no idle gap beyond the IDLE cycle.
REQ-024 busy SHALL be 1 in SCAN, EMIT and END.

Reset
REQ-025 rst SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_end=0, rsp_data=0x00, busy=0, counter=0x00, match_cnt=0.
REQ-026 rst mid-request SHALL abandon it with no end beat; the next accepted request starts cleanly.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-028 Macro CODE_INV_CNT_EN defined: match_cnt SHALL exist, clear to 0 on request accept, increment on each match-beat handshake (not the end beat), and hold its value through END and IDLE.
REQ-029 Macro CODE_INV_CNT_EN undefined: the match_cnt port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-030 req_code=0xC0, rsp_ready=1 -> beats 0x04, 0xD1, then the end beat; match_cnt=2.
REQ-031 req_code=0x05 -> only the end beat (rsp_end=1, rsp_data=0x00) in cycle T+257; match_cnt=0.
REQ-032 req_code=0xFE -> beat 0xFF, then the end beat; req_code=0x0A -> beat 0xFB, then the end beat; req_code=0x00 -> beat 0x00, then the end beat.
REQ-033 req_code=0xC0 with random rsp_ready stalls -> the same sequence, rsp_data stable while stalled, req_ready=0 throughout.
REQ-034 rst asserted during the scan for 0xC0 after beat 0x04 -> outputs at reset values next cycle, no end beat; a following 0x0A request yields 0xFB, then the end beat.
REQ-035 Exhaustive check over all 256 req_code values -> union of emitted beats equals 0x00..0xFF, each value appearing exactly once.
